ex_stage_md: RTL and testbench

Parametrised execute stage for the MIPS-R2000 pipeline. It sits between the ID/EX and EX/MEM pipeline registers and owns the EX/MEM register itself. It adds the multi-cycle work the single-cycle EX lacked: an iterative multiply/divide unit with HI/LO registers, MFHI/MFLO, SLT, and a valid/ready stall handshake back to decode. Single-cycle ALU ops keep issuing while a multiply or divide runs in the background.

---
 rtl/ex_md_pkg.sv | 47 ++++
 rtl/ex_stage_md_md_unit.sv | 137 +++++++++++++
 rtl/ex_stage_md.sv | 126 ++++++++++++
 tb/tb_ex_stage_md.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_md_pkg.sv
// Shared types and constants for the execute stage and its multiply/divide unit.
package ex_md_pkg;

  // Result selector for the single-cycle ALU path.
  // PASS drives a constant zero onto the result bus.
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_MFHI,
    ALU_MFLO,
    ALU_PASS
  } alu_op_t;

  // R-type funct codes (imm[5:0]) decoded when alu_op = 2'b10.
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_t;

  // Multiply/divide operation kinds.
  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } md_op_t;

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, then HI/LO are written.
module md_unit
  import ex_md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  md_op_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_t         state_reg, state_next;
  md_op_t            op_reg;
  logic              neg_a_reg, neg_b_reg;
  logic [DATA_W-1:0] dvd_raw_reg;  // untouched dividend, returned as HI on divide by zero
  logic [DATA_W-1:0] opnd_reg;     // multiplicand or divisor magnitude
  logic [DATA_W-1:0] acc_reg;      // product high half / partial remainder
  logic [DATA_W-1:0] shr_reg;      // multiplier -> product low half / dividend -> quotient
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg;

  logic              start_signed;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0] acc_step, shr_step;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] fix_hi, fix_lo;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  assign start_signed = (op == MD_MULT) || (op == MD_DIV);
  assign busy = (state_reg != MD_IDLE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= MD_IDLE;
    else        state_reg <= state_next;
  end

  // Next state: IDLE -> RUN for DATA_W steps -> FIX -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: if (start) state_next = MD_RUN;
      MD_RUN:  if (cnt_reg == CNT_W'(DATA_W - 1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (shr_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg, shr_reg[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    acc_step  = mul_sum[DATA_W:1];
    shr_step  = {mul_sum[0], shr_reg[DATA_W-1:1]};
    if (op_reg == MD_DIV || op_reg == MD_DIVU) begin
      if (div_shift >= {1'b0, opnd_reg}) begin
        acc_step = div_diff[DATA_W-1:0];
        shr_step = {shr_reg[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = div_shift[DATA_W-1:0];
        shr_step = {shr_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Sign correction and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    prod = {acc_reg, shr_reg};
    if (neg_a_reg ^ neg_b_reg) prod = -prod;
    fix_hi = prod[2*DATA_W-1:DATA_W];
    fix_lo = prod[DATA_W-1:0];
    if (op_reg == MD_DIV || op_reg == MD_DIVU) begin
      if (opnd_reg == '0) begin
        fix_hi = dvd_raw_reg;
        fix_lo = '1;
      end else begin
        fix_lo = (neg_a_reg ^ neg_b_reg) ? -shr_reg : shr_reg;
        fix_hi = neg_a_reg ? -acc_reg : acc_reg;
      end
    end
  end

  // Operand latch, iteration datapath and HI/LO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= MD_MULT;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      dvd_raw_reg <= '0;
      opnd_reg    <= '0;
      acc_reg     <= '0;
      shr_reg     <= '0;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        MD_IDLE: if (start) begin
          op_reg      <= op;
          neg_a_reg   <= start_signed && a[DATA_W-1];
          neg_b_reg   <= start_signed && b[DATA_W-1];
          dvd_raw_reg <= a;
          opnd_reg    <= mag(b, start_signed);
          acc_reg     <= '0;
          shr_reg     <= mag(a, start_signed);
          cnt_reg     <= '0;
        end
        MD_RUN: begin
          acc_reg <= acc_step;
          shr_reg <= shr_step;
          cnt_reg <= cnt_reg + 1'b1;
        end
        MD_FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: ALU decode, HI/LO access, MD issue with dependency stall,
// and the EX/MEM pipeline register.
module ex_stage_md
  import ex_md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [3:0]        ex,
  input  logic [2:0]        m_ex,
  input  logic [1:0]        wb_ex,
  output logic [DATA_W-1:0] res,
  output logic              zero,
  output logic [REG_W-1:0]  write_register,
  output logic [2:0]        m_mem,
  output logic [1:0]        wb_mem,
  output logic              out_valid,
  output logic              md_busy
);

  logic [DATA_W-1:0] opb, alu_res, hi, lo;
  alu_op_t           alu_sel;
  md_op_t            md_sel;
  logic              is_md, needs_md, stall, accept;

  assign opb = ex[0] ? imm : data_2;

  // Decode alu_op / funct into a result selector and MD request.
  always_comb begin
    alu_sel = ALU_PASS;
    md_sel  = MD_MULT;
    is_md   = 1'b0;
    case (ex[2:1])
      2'b00: alu_sel = ALU_ADD;
      2'b01: alu_sel = ALU_SUB;
      2'b11: alu_sel = ALU_OR;
      default: begin
        case (imm[5:0])
          FN_ADD:   alu_sel = ALU_ADD;
          FN_SUB:   alu_sel = ALU_SUB;
          FN_AND:   alu_sel = ALU_AND;
          FN_OR:    alu_sel = ALU_OR;
          FN_NOR:   alu_sel = ALU_NOR;
          FN_SLT:   alu_sel = ALU_SLT;
          FN_MFHI:  alu_sel = ALU_MFHI;
          FN_MFLO:  alu_sel = ALU_MFLO;
          FN_MULT:  begin is_md = 1'b1; md_sel = MD_MULT;  end
          FN_MULTU: begin is_md = 1'b1; md_sel = MD_MULTU; end
          FN_DIV:   begin is_md = 1'b1; md_sel = MD_DIV;   end
          FN_DIVU:  begin is_md = 1'b1; md_sel = MD_DIVU;  end
          default:  alu_sel = ALU_PASS;
        endcase
      end
    endcase
  end

  // Anything touching HI/LO or the MD unit waits while it iterates.
  assign needs_md = is_md || (alu_sel == ALU_MFHI) || (alu_sel == ALU_MFLO);
  assign stall    = in_valid && md_busy && needs_md;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;

  // Single-cycle result mux.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD:  alu_res = data_1 + opb;
      ALU_SUB:  alu_res = data_1 - opb;
      ALU_AND:  alu_res = data_1 & opb;
      ALU_OR:   alu_res = data_1 | opb;
      ALU_NOR:  alu_res = ~(data_1 | opb);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(data_1) < $signed(opb))};
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  md_unit #(.DATA_W(DATA_W)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_md),
    .op    (md_sel),
    .a     (data_1),
    .b     (opb),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );

  // EX/MEM register: load the instruction when accepted, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res            <= '0;
      zero           <= 1'b0;
      write_register <= '0;
      m_mem          <= '0;
      wb_mem         <= '0;
      out_valid      <= 1'b0;
    end else if (accept) begin
      res            <= alu_res;
      zero           <= (alu_res == '0);
      write_register <= ex[3] ? rd : rt;
      m_mem          <= is_md ? 3'b000 : m_ex;
      wb_mem         <= is_md ? 2'b00 : wb_ex;
      out_valid      <= 1'b1;
    end else begin
      res            <= '0;
      zero           <= 1'b0;
      write_register <= '0;
      m_mem          <= '0;
      wb_mem         <= '0;
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: driver issues instructions and pushes
// expected EX/MEM contents; a monitor pops and compares on every valid output.
module tb_ex_stage_md;
  import ex_md_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_1 = '0, data_2 = '0, imm = '0;
  logic [RW-1:0] rt = '0, rd = '0;
  logic [3:0]    ex = '0;
  logic [2:0]    m_ex = '0;
  logic [1:0]    wb_ex = '0;
  logic [DW-1:0] res;
  logic          zero;
  logic [RW-1:0] write_register;
  logic [2:0]    m_mem;
  logic [1:0]    wb_mem;
  logic          out_valid, md_busy;

  ex_stage_md #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_1(data_1), .data_2(data_2), .imm(imm), .rt(rt), .rd(rd),
    .ex(ex), .m_ex(m_ex), .wb_ex(wb_ex), .res(res), .zero(zero),
    .write_register(write_register), .m_mem(m_mem), .wb_mem(wb_mem),
    .out_valid(out_valid), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic          zero;
    logic [RW-1:0] wr;
    logic [2:0]    m;
    logic [1:0]    wb;
    bit            chk_res;
    int unsigned   stamp;
  } exp_t;
  exp_t exq[$];

  // Architectural model state: HI/LO updated at issue, busy countdown.
  logic [DW-1:0] hi_m = '0, lo_m = '0;
  int md_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic bit is_dep(input logic [1:0] aop, input logic [5:0] fn);
    return (aop == 2'b10) && (fn == 6'h10 || fn == 6'h12 || fn == 6'h18 ||
                              fn == 6'h19 || fn == 6'h1A || fn == 6'h1B);
  endfunction

  // Reference behaviour for the instruction currently on the inputs.
  task automatic model_accept();
    exp_t e;
    logic [DW-1:0] a, b, r;
    logic [63:0] p;
    longint sa, sb;
    a = data_1;
    b = ex[0] ? imm : data_2;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    e.chk_res = 1'b1;
    e.m = m_ex;
    e.wb = wb_ex;
    e.wr = ex[3] ? rd : rt;
    e.stamp = cyc + 1;
    case (ex[2:1])
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: r = a | b;
      default: begin
        case (imm[5:0])
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2A: r = (sa < sb) ? 1 : 0;
          6'h10: r = hi_m;
          6'h12: r = lo_m;
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            e.chk_res = 1'b0;
            e.m = '0;
            e.wb = '0;
            md_left = DW + 1;
            if (imm[5:0] == 6'h18) begin
              p = sa * sb;
              hi_m = p[63:32]; lo_m = p[31:0];
            end else if (imm[5:0] == 6'h19) begin
              p = {32'h0, a} * {32'h0, b};
              hi_m = p[63:32]; lo_m = p[31:0];
            end else if (b == 0) begin
              hi_m = a; lo_m = '1;
            end else if (imm[5:0] == 6'h1A) begin
              p = sa / sb; lo_m = p[31:0];
              p = sa % sb; hi_m = p[31:0];
            end else begin
              lo_m = a / b; hi_m = a % b;
            end
          end
          default: r = '0;
        endcase
      end
    endcase
    e.res = r;
    e.zero = (r == 0);
    exq.push_back(e);
  endtask

  // One clock: check handshake/busy mid-cycle, then advance the model at the edge.
  task automatic tick(output bit acc);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = !(in_valid && (md_left > 0) && is_dep(ex[2:1], imm[5:0]));
    chk("in_ready", in_ready, exp_rdy);
    chk("md_busy", md_busy, md_left > 0);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (md_left > 0) md_left--;
    if (acc) model_accept();
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic send(input logic [1:0] aop, input logic src, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] iv,
                      input logic [RW-1:0] rtv, input logic [RW-1:0] rdv, input logic rdst,
                      input logic [2:0] mv, input logic [1:0] wbv, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; data_1 = a; data_2 = b; imm = iv;
    rt = rtv; rd = rdv; ex = {rdst, aop, src}; m_ex = mv; wb_ex = wbv;
    for (int n = 0; n < 200; n++) begin
      tick(acc);
      if (acc) break;
      stalls++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=stalled required=accepted within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rdv, output int stalls);
    send(2'b10, 1'b0, a, b, {26'h0, fn}, 5'd0, rdv, 1'b1, 3'b000, 2'b10, stalls);
  endtask

  // Monitor: every valid output pops one expectation; bubbles must be all-zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=res 0x%0h required=no output", res);
        end else begin
          exp_t e;
          e = exq.pop_front();
          chk("latency_cycle", cyc, e.stamp);
          if (e.chk_res) begin
            chk("res", res, e.res);
            chk("zero", zero, e.zero);
          end
          chk("write_register", write_register, e.wr);
          chk("m_mem", m_mem, e.m);
          chk("wb_mem", wb_mem, e.wb);
        end
      end else begin
        chk("bubble_fields", {res, write_register, m_mem, wb_mem}, '0);
      end
    end
  end

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    v = $urandom;
    case ($urandom % 6)
      0: v = '0;
      1: v = 1;
      2: v = '1;
      3: v = 32'h8000_0000;
      4: v = $urandom % 16;
      default: ;
    endcase
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int st, left;
    logic [5:0] fn_tab [13];
    logic [1:0] aop;
    logic [5:0] fn;
    logic [DW-1:0] iv;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h10,
               6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h03};

    // Reset state.
    #2;
    chk("rst_outputs", {res, zero, write_register, m_mem, wb_mem, out_valid, md_busy}, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic ALU ops.
    rtype(6'h20, 32'd7, 32'd5, 5'd3, st);
    rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd4, st);
    send(2'b01, 1'b0, 32'd5, 32'd5, 32'h0, 5'd6, 5'd7, 1'b0, 3'b101, 2'b01, st);
    send(2'b00, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFF0, 5'd8, 5'd9, 1'b0, 3'b010, 2'b11, st);
    idle(1);

    // MULT then dependent MFLO / MFHI.
    rtype(6'h18, 32'hFFFF_FFFF, 32'd2, 5'd0, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd10, st);
    chk("mflo_stall_cycles", st, DW + 1);
    rtype(6'h10, 32'd0, 32'd0, 5'd11, st);
    chk("mfhi_no_stall", st, 0);

    // Signed divide and divide by zero.
    rtype(6'h1A, -32'sd7, 32'd2, 5'd0, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd12, st);
    rtype(6'h10, 32'd0, 32'd0, 5'd13, st);
    rtype(6'h1B, 32'd7, 32'd0, 5'd0, st);
    rtype(6'h12, 32'd0, 32'd0, 5'd14, st);
    rtype(6'h10, 32'd0, 32'd0, 5'd15, st);

    // Independent ops run under a DIVU; a second divide waits.
    rtype(6'h1B, 32'd100, 32'd7, 5'd0, st);
    rtype(6'h20, 32'd1, 32'd2, 5'd16, st);
    chk("add_under_md_stall", st, 0);
    send(2'b11, 1'b0, 32'h0F00, 32'h00F0, 32'h0, 5'd17, 5'd18, 1'b1, 3'b001, 2'b10, st);
    chk("or_under_md_stall", st, 0);
    send(2'b00, 1'b1, 32'd40, 32'd0, 32'd2, 5'd19, 5'd20, 1'b0, 3'b000, 2'b10, st);
    chk("addi_under_md_stall", st, 0);
    left = md_left;
    rtype(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, st);
    chk("div_second_stall", st, left);
    rtype(6'h12, 32'd0, 32'd0, 5'd21, st);
    rtype(6'h10, 32'd0, 32'd0, 5'd22, st);

    // Reset in the middle of a multiply.
    rtype(6'h19, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, st);
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_md_busy", md_busy, 1'b0);
    chk("midrst_outputs", {res, zero, write_register, m_mem, wb_mem, out_valid}, '0);
    hi_m = '0; lo_m = '0; md_left = 0;
    exq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rtype(6'h10, 32'd0, 32'd0, 5'd23, st);
    chk("post_rst_mfhi_stall", st, 0);
    rtype(6'h12, 32'd0, 32'd0, 5'd24, st);

    // Randomised mix.
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) idle(1);
      aop = 2'($urandom % 4);
      iv = $urandom;
      fn = fn_tab[$urandom % 13];
      if (fn >= 6'h18 && fn <= 6'h1B && ($urandom % 3 != 0)) fn = 6'h20;
      if (aop == 2'b10) iv[5:0] = fn;
      left = is_dep(aop, iv[5:0]) ? md_left : 0;
      send(aop, (aop == 2'b10) ? 1'b0 : 1'($urandom % 2), rnd_val(), rnd_val(), iv,
           5'($urandom), 5'($urandom), 1'($urandom % 2), 3'($urandom), 2'($urandom), st);
      chk("rand_stall_cycles", st, left);
    end

    idle(3);
    chk("queue_drained", exq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
